sqrt_iter: RTL

Parametrised iterative integer square-root unit. It is the next generation of the codebase's `sqrt` block and keeps its start/ready port style. New over `sqrt`:
- configurable root bits resolved per cycle;
- floor or round-to-nearest result;
- remainder output;
- explicit busy flag.

It sits in the FP_sqrt datapath as the mantissa root engine and is usable standalone on integers.

---
 rtl/sqrt_pkg.sv | 24 ++
 rtl/sqrt_step.sv | 34 +++
 rtl/sqrt_iter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the iterative square-root engine.
// Latency and handshake are defined by sqrt_iter; this file holds no logic.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ROUND_FLOOR   = 0;
  localparam int ROUND_NEAREST = 1;

  // A zero bpc only happens in an illegal configuration; avoid dividing by it.
  function automatic int iter_count(input int width, input int bpc);
    return (bpc > 0) ? width / (2 * bpc) : 1;
  endfunction

  function automatic int rem_width(input int width);
    return width / 2 + 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One non-restoring square-root step: consumes two radicand bits, yields one root bit.
// Purely combinational; no handshake.
module sqrt_step #(
  parameter int QW = 32
) (
  input  logic [QW+1:0] rem_i,
  input  logic [QW-1:0] root_i,
  input  logic [1:0]    bits_i,
  output logic [QW+1:0] rem_o,
  output logic [QW-1:0] root_o
);

  localparam int RW = QW + 2;

  logic [RW-1:0] shifted;
  logic [RW-1:0] trial;
  logic          unused_rem_bit;

  // The true remainder always fits RW bits signed, so the bit shifted out
  // below the sign carries no information and the arithmetic wraps correctly.
  assign unused_rem_bit = rem_i[RW-2];

  always_comb begin
    shifted = {rem_i[RW-3:0], bits_i};
    trial   = {root_i, 2'b01};
    rem_o   = shifted - trial;
    if (rem_i[RW-1]) begin
      trial = {root_i, 2'b11};
      rem_o = shifted + trial;
    end
    root_o = QW'({root_i, ~rem_o[RW-1]});
  end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root, BPC root bits per cycle, floor or round-to-nearest.
// ready rises ITER+1 edges after an accepted start and holds until the next accepted start.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BPC   = 1,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH/2:0] rem
);

  localparam int QW   = WIDTH / 2;
  localparam int OW   = QW + 1;
  localparam int RW   = rem_width(WIDTH);
  localparam int ITER = iter_count(WIDTH, BPC);
  localparam int CW   = $clog2(ITER + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("sqrt_iter: WIDTH must be even and at least 4");
  end
  if (BPC < 1 || (QW % BPC) != 0) begin : g_bad_bpc
    $error("sqrt_iter: BPC must divide WIDTH/2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [RW-1:0]    prem_q, prem_d;
  logic [QW-1:0]    root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [QW:0]      rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [RW-1:0]    rem_ch  [BPC+1];
  logic [QW-1:0]    root_ch [BPC+1];

  logic [RW-1:0]    rem_fix;
  logic             round_up;
  logic [OW-1:0]    rounded;

  assign rem_ch[0]  = prem_q;
  assign root_ch[0] = root_q;

  for (genvar k = 0; k < BPC; k++) begin : g_step
    sqrt_step #(
      .QW (QW)
    ) u_step (
      .rem_i  (rem_ch[k]),
      .root_i (root_ch[k]),
      .bits_i (rad_q[WIDTH-1-2*k -: 2]),
      .rem_o  (rem_ch[k+1]),
      .root_o (root_ch[k+1])
    );
  end

  // Final correction: a negative partial remainder is restored by adding 2*root+1.
  always_comb begin
    rem_fix  = prem_q;
    if (prem_q[RW-1]) begin
      rem_fix = prem_q + RW'({root_q, 1'b1});
    end
    round_up = (ROUND == ROUND_NEAREST) && (rem_fix > RW'(root_q));
    rounded  = {1'b0, root_q} + OW'(round_up);
  end

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    prem_d  = prem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rem_d   = rem_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rad_d   = num;
          prem_d  = '0;
          root_d  = '0;
          cnt_d   = CW'(ITER);
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d  = rad_q << (2 * BPC);
        prem_d = rem_ch[BPC];
        root_d = root_ch[BPC];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        out_d   = WIDTH'(rounded);
        rem_d   = rem_fix[QW:0];
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      prem_q  <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      prem_q  <= prem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign out   = out_q;
  assign rem   = rem_q;

endmodule
